booth_seq_mult: RTL and testbench

Iterative radix-4 Modified Booth multiplier for the FMA significand datapath: accepts two unsigned WIDTH-bit significands and produces the exact 2·WIDTH-bit product, retiring one Booth digit per clock. It sits directly downstream of the radix-4 Booth encoder, consuming its single/double/neg outputs to select and accumulate partial products. It serves as the area-lean alternative to the parallel partial-product array feeding the FMA adder.

---
 rtl/booth_seq_mult_pkg.sv | 26 ++
 rtl/booth_pp_sel.sv | 25 ++
 rtl/booth_r4_enc.sv | 32 +++
 rtl/booth_seq_mult.sv | 119 +++++++++++
 tb/tb_booth_seq_mult.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/booth_seq_mult_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier and its encoder:
// controller states, digit-count derivation and the Booth triplet encodings.
package booth_seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
  localparam logic [2:0] BOOTH_POS1_A = 3'b001;
  localparam logic [2:0] BOOTH_POS1_B = 3'b010;
  localparam logic [2:0] BOOTH_POS2   = 3'b011;
  localparam logic [2:0] BOOTH_NEG2   = 3'b100;
  localparam logic [2:0] BOOTH_NEG1_A = 3'b101;
  localparam logic [2:0] BOOTH_NEG1_B = 3'b110;
  localparam logic [2:0] BOOTH_ZERO_N = 3'b111;

  // One extra digit covers the zero-extension so unsigned multipliers recode exactly
  function automatic int calcNdig(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product selector: picks 0, a or 2a and optionally negates it,
// yielding a WIDTH+2-bit two's-complement partial product.
module booth_pp_sel #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic             single,
  input  logic             double,
  input  logic             neg,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] w_mag;

  // Negation is ones' complement plus one on the full WIDTH+2-bit magnitude
  always_comb begin
    w_mag = '0;
    if (single)
      w_mag = {2'b00, a};
    else if (double)
      w_mag = {1'b0, a, 1'b0};
    pp = neg ? (~w_mag + (WIDTH+2)'(1)) : w_mag;
  end

endmodule

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth encoder: decodes one multiplier triplet into single/double/neg
// selects for the partial-product selector.
module booth_r4_enc
  import booth_seq_mult_pkg::*;
(
  input  logic [2:0] triplet,
  output logic       single,
  output logic       double,
  output logic       neg
);

  // 111 is decoded as a plain zero so it never produces a -0 correction term
  always_comb begin
    single = 1'b0;
    double = 1'b0;
    neg    = 1'b0;
    case (triplet)
      BOOTH_POS1_A, BOOTH_POS1_B: single = 1'b1;
      BOOTH_POS2:                 double = 1'b1;
      BOOTH_NEG2: begin
        double = 1'b1;
        neg    = 1'b1;
      end
      BOOTH_NEG1_A, BOOTH_NEG1_B: begin
        single = 1'b1;
        neg    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier: retires one Booth digit per clock and
// returns the exact unsigned 2*WIDTH-bit product through a valid/ready pair.
module booth_seq_mult
  import booth_seq_mult_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int NDIG = calcNdig(WIDTH);
  localparam int CNTW = $clog2(NDIG);
  localparam int ACCW = 2 * WIDTH + 2;
  localparam int SRW  = WIDTH + 3;

  state_t             r_state;
  state_t             w_stateNext;
  logic [WIDTH-1:0]   r_a;
  logic [SRW-1:0]     r_bShift;
  logic [ACCW-1:0]    r_acc;
  logic [CNTW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_outValid;

  logic               w_single;
  logic               w_double;
  logic               w_neg;
  logic [WIDTH+1:0]   w_pp;
  logic [ACCW-1:0]    w_ppShift;
  logic [ACCW-1:0]    w_accNext;
  logic               w_lastDigit;

  booth_r4_enc u_enc (
    .triplet (r_bShift[2:0]),
    .single  (w_single),
    .double  (w_double),
    .neg     (w_neg)
  );

  booth_pp_sel #(.WIDTH(WIDTH)) u_ppSel (
    .a      (r_a),
    .single (w_single),
    .double (w_double),
    .neg    (w_neg),
    .pp     (w_pp)
  );

  assign w_lastDigit = (r_cnt == CNTW'(NDIG - 1));
  assign w_ppShift   = {{(ACCW-WIDTH-2){w_pp[WIDTH+1]}}, w_pp} << {r_cnt, 1'b0};
  assign w_accNext   = r_acc + w_ppShift;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_outValid;
  assign product   = r_product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_stateNext = RUN;
      RUN:     if (w_lastDigit) w_stateNext = DONE;
      DONE:    if (out_ready)   w_stateNext = IDLE;
      default:                  w_stateNext = IDLE;
    endcase
  end

  // Counter holds at NDIG-1 on the final digit and is only cleared by the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_bShift   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_product  <= '0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_bShift <= {2'b00, b, 1'b0};
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_acc    <= w_accNext;
          r_bShift <= r_bShift >> 2;
          if (w_lastDigit) begin
            r_product  <= w_accNext[2*WIDTH-1:0];
            r_outValid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        DONE: begin
          if (out_ready)
            r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomised checks of booth_seq_mult: latency, handshake,
// backpressure, mid-run reset and product correctness.
module tb_booth_seq_mult;

  localparam int WIDTH = 24;
  localparam int NDIG  = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] product;

  int total = 0;
  int bad   = 0;

  booth_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Waits for in_ready, pulses in_valid for one edge, then counts edges until out_valid
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input int stall, output int lat, output logic readyLow);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    lat = 0;
    readyLow = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) readyLow = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [WIDTH-1:0] av,
                           input logic [WIDTH-1:0] bv, input logic [2*WIDTH-1:0] exp);
    int   lat;
    logic rl;
    applyStimulus(av, bv, 0, lat, rl);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(NDIG));
    checkOutput({tag, "_readyLow"}, 64'(rl), 64'(1));
    checkOutput({tag, "_product"}, 64'(product), 64'(exp));
    drain();
    checkOutput({tag, "_consumed"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    int             lat;
    logic           rl;
    logic [2*WIDTH-1:0] held;
    logic           sawValid;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_inReady", 64'(in_ready), 64'(1));
    checkOutput("reset_outValid", 64'(out_valid), 64'(0));
    checkOutput("reset_product", 64'(product), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    runVector("one_by_one", 24'h000001, 24'h000001, 48'h000000000001);
    runVector("max_by_max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    runVector("alt_digits", 24'h800000, 24'hAAAAAA, 48'h555555000000);
    runVector("zero_mult",  24'h123456, 24'h000000, 48'h000000000000);

    // Backpressure with in_valid pulses that must be ignored
    applyStimulus(24'h001234, 24'h005678, 0, lat, rl);
    checkOutput("bp_product", 64'(product), 64'h0000000006260060);
    held = product;
    for (int i = 0; i < 20; i++) begin
      a = 24'h000007;
      b = 24'h000007;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      if (i % 5 == 4) begin
        checkOutput("bp_stable", 64'(product), 64'(held));
        checkOutput("bp_holdState", 64'({out_valid, in_ready}), 64'(2'b10));
      end
    end
    in_valid = 1'b0;
    drain();
    checkOutput("bp_release_inReady", 64'(in_ready), 64'(1));
    runVector("after_bp", 24'h000002, 24'h000003, 48'h000000000006);

    // Asynchronous reset in the middle of RUN
    a = 24'hFFFFFF;
    b = 24'hFFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_outValid", 64'(out_valid), 64'(0));
    checkOutput("midrst_inReady", 64'(in_ready), 64'(1));
    checkOutput("midrst_product", 64'(product), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst_noPulse", 64'(sawValid), 64'(0));
    runVector("post_rst", 24'h000003, 24'h000005, 48'h00000000000F);

    // Random operands with input and output stalls
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      applyStimulus(ra, rb, int'($urandom_range(0, 3)), lat, rl);
      checkOutput("rand_latency", 64'(lat), 64'(NDIG));
      checkOutput("rand_product", 64'(product), 64'(ra) * 64'(rb));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      checkOutput("rand_heldValid", 64'(out_valid), 64'(1));
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
